hack_ctrl: RTL and testbench
============================

HACK_CTRL -- requirements
Module: hack_ctrl

Interface
REQ-001 clk  in  1  rising-edge clock; all state updates on posedge.
REQ-002 reset  in  1  asynchronous, active-high; one clock, no other reset.
REQ-003 instr_req  out  1  instruction fetch request, address = pc.
REQ-004 instr_ack  in  1  fetch ack; instr valid in the same cycle.
REQ-005 instr  in  16  Hack instruction word.
REQ-006 pc  out  15  program counter.
REQ-007 a_val  in  15  current A register value from datapath.
REQ-008 mem_req  out  1  data memory request, address = A.
REQ-009 mem_we  out  1  1 = write ALU out to M; 0 = read.
REQ-010 mem_ack  in  1  data memory ack.
REQ-011 m_load  out  1  one-cycle strobe: datapath latches read data as M.
REQ-012 zx, nx, zy, ny, f, no  out  1 each  ALU control bits.
REQ-013 alu_am  out  1  ALU y operand select: 0 = A, 1 = M.
REQ-014 alu_zr, alu_ng  in  1 each  ALU status flags.
REQ-015 load_a  out  1  A register write strobe.
REQ-016 a_sel  out  1  A source: 0 = instruction (ir[14:0]), 1 = ALU out.
REQ-017 load_d  out  1  D register write strobe.

Function
REQ-018 Internal ir[15:0] SHALL capture instr on the cycle instr_ack=1 in FETCH.
REQ-019 FSM states SHALL be FETCH, DECODE, MEM_RD, EXEC, MEM_WR, COMMIT.
REQ-020 FETCH: instr_req=1; stay while instr_ack=0; on ack -> DECODE.
REQ-021 DECODE, ir[15]=0: load_a=1, a_sel=0, pc<=pc+1, -> FETCH.
REQ-022 DECODE, ir[15]=1: -> MEM_RD if ir[12]=1, else -> EXEC; no strobes.
REQ-023 MEM_RD: mem_req=1, mem_we=0; stay until mem_ack; on ack: m_load=1 that cycle, -> EXEC.
REQ-024 EXEC: latch alu_zr/alu_ng into flag registers; -> MEM_WR if ir[3]=1, else -> COMMIT.
REQ-025 MEM_WR: mem_req=1, mem_we=1; stay until mem_ack; on ack -> COMMIT.
REQ-026 COMMIT: load_a=ir[5] with a_sel=1, load_d=ir[4], update pc, -> FETCH.
REQ-027 Jump SHALL be (ir[2]&ng_f)|(ir[1]&zr_f)|(ir[0]&~ng_f&~zr_f), using the latched flags.
REQ-028 COMMIT pc SHALL load a_val when jump is true, else pc+1; a_val sampled before the same-edge A write, i.e. the old A.
REQ-029 pc+1 SHALL wrap 0x7FFF -> 0x0000.
REQ-030 When ir[15]=1: {zx,nx,zy,ny,f,no}=ir[11:6] and alu_am=ir[12]; otherwise all 0.
REQ-031 These outputs SHALL be held stable from DECODE through COMMIT.
REQ-032 A and D SHALL NOT change before a memory write completes, so a write uses the pre-instruction A as address.
REQ-033 instr_req, mem_req, mem_we, m_load, load_a, load_d SHALL be 0 in every state/condition not listed above.
REQ-034 Acks arriving outside the matching request state SHALL be ignored.
REQ-035 Minimum latency: A-instruction 2 cycles; C-instruction 4; +1 per memory access plus ack wait cycles.

Reset
REQ-036 While reset=1, asynchronously: state=FETCH, pc=0, ir=0, flags=0.
REQ-037 While reset=1, all strobes/requests SHALL be 0, including instr_req.
REQ-038 Reset mid-operation SHALL abandon the instruction with no further strobes.
REQ-039 After reset falls, the first instr_req SHALL assert in the next cycle with pc=0.

Verification
REQ-040 A-instr: reset, instr=0x0005 acked immediately -> DECODE cycle load_a=1, a_sel=0; pc=1; instr_req again 2 cycles after the first.
REQ-041 D=A: instr=0xEC10 -> controls 110000, alu_am=0, no mem_req, COMMIT load_d=1 only, pc+1, 4 cycles total.
REQ-042 M=D+M with a_val=0x0010: instr=0xF088 -> read (m_load pulse), then write (mem_we=1) held through 3 ack-wait cycles, COMMIT with no load, pc+1.
REQ-043 D;JGT with a_val=0x0123: instr=0xE301 -> zr=0, ng=0 in EXEC gives pc=0x0123; zr=1 gives pc+1.
REQ-044 AM=M-1;JEQ, a_val=0x0040, zr=1: -> write to old A, then COMMIT load_a=1, a_sel=1, pc=0x0040.
REQ-045 Reset asserted in MEM_WR with mem_ack=0 -> mem_req drops immediately, pc=0, no load strobes; restart fetch at pc=0.

Source files
------------

// File: rtl/hack_ctrl_if.sv
// Controller-side bundle: fetch port, data memory port, ALU controls and register strobes.
interface hack_ctrl_if;
  logic        instr_req;
  logic        instr_ack;
  logic [15:0] instr;
  logic [14:0] pc;
  logic [14:0] a_val;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack;
  logic        m_load;
  logic        zx, nx, zy, ny, f, no;
  logic        alu_am;
  logic        alu_zr, alu_ng;
  logic        load_a;
  logic        a_sel;
  logic        load_d;

  modport master (
    output instr_req, pc, mem_req, mem_we, m_load,
           zx, nx, zy, ny, f, no, alu_am, load_a, a_sel, load_d,
    input  instr_ack, instr, a_val, mem_ack, alu_zr, alu_ng
  );

  modport slave (
    input  instr_req, pc, mem_req, mem_we, m_load,
           zx, nx, zy, ny, f, no, alu_am, load_a, a_sel, load_d,
    output instr_ack, instr, a_val, mem_ack, alu_zr, alu_ng
  );
endinterface

// File: rtl/hack_ctrl.sv
// Hack CPU sequencer: fetch, optional M read, execute, optional M write, commit.
module hack_ctrl (
  input  logic         clk,
  input  logic         reset,
  hack_ctrl_if.master  bus
);

  typedef enum logic [2:0] {
    FETCH, DECODE, MEM_RD, EXEC, MEM_WR, COMMIT
  } state_e;

  state_e      state_q, state_d;
  logic [14:0] pc_q, pc_d;
  logic [15:0] ir_q, ir_d;
  logic        zr_q, zr_d;
  logic        ng_q, ng_d;
  logic [14:0] pc_inc;
  logic        jump;
  logic        unused_ir_bits;

  // ir[14:13] are don't-care bits of a C-instruction
  assign unused_ir_bits = ^ir_q[14:13];

  // 15-bit add wraps 0x7FFF -> 0x0000 on its own
  assign pc_inc = pc_q + 15'd1;
  assign jump   = (ir_q[2] & ng_q) | (ir_q[1] & zr_q) | (ir_q[0] & ~ng_q & ~zr_q);

  // State and architectural registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      zr_q    <= 1'b0;
      ng_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      zr_q    <= zr_d;
      ng_q    <= ng_d;
    end
  end

  // Next-state, instruction capture, flag latch and pc update
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    ir_d    = ir_q;
    zr_d    = zr_q;
    ng_d    = ng_q;
    unique case (state_q)
      FETCH: begin
        if (bus.instr_ack) begin
          ir_d    = bus.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        if (!ir_q[15]) begin
          pc_d    = pc_inc;
          state_d = FETCH;
        end else begin
          state_d = ir_q[12] ? MEM_RD : EXEC;
        end
      end
      MEM_RD: begin
        if (bus.mem_ack) state_d = EXEC;
      end
      EXEC: begin
        zr_d    = bus.alu_zr;
        ng_d    = bus.alu_ng;
        state_d = ir_q[3] ? MEM_WR : COMMIT;
      end
      MEM_WR: begin
        if (bus.mem_ack) state_d = COMMIT;
      end
      COMMIT: begin
        // a_val here is still the old A; the A write lands on this same edge
        pc_d    = jump ? bus.a_val : pc_inc;
        state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
  end

  // Strobes, requests and ALU controls; everything forced low while reset is high
  always_comb begin
    bus.instr_req = 1'b0;
    bus.mem_req   = 1'b0;
    bus.mem_we    = 1'b0;
    bus.m_load    = 1'b0;
    bus.load_a    = 1'b0;
    bus.a_sel     = 1'b0;
    bus.load_d    = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH:  bus.instr_req = 1'b1;
        DECODE: bus.load_a    = ~ir_q[15];
        MEM_RD: begin
          bus.mem_req = 1'b1;
          bus.m_load  = bus.mem_ack;
        end
        MEM_WR: begin
          bus.mem_req = 1'b1;
          bus.mem_we  = 1'b1;
        end
        COMMIT: begin
          bus.load_a = ir_q[5];
          bus.a_sel  = 1'b1;
          bus.load_d = ir_q[4];
        end
        default: ;
      endcase
    end
    bus.pc = pc_q;
    {bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no} = ir_q[15] ? ir_q[11:6] : 6'b0;
    bus.alu_am = ir_q[15] & ir_q[12];
  end

endmodule

// File: tb/tb_hack_ctrl.sv
module tb_hack_ctrl;

  logic clk = 1'b0;
  logic reset = 1'b1;

  hack_ctrl_if bus ();

  hack_ctrl dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // One cycle of stimulus plus the outputs the spec requires in that cycle
  typedef struct packed {
    logic        rst;
    logic        iack;
    logic [15:0] instr;
    logic [14:0] aval;
    logic        mack;
    logic        zr;
    logic        ng;
    logic        e_ireq;
    logic [14:0] e_pc;
    logic        e_mreq;
    logic        e_mwe;
    logic        e_mload;
    logic        e_la;
    logic        e_asel;
    logic        e_ld;
    logic        chk_ctrl;
    logic [5:0]  e_alu;
    logic        e_am;
  } rec_t;

  rec_t        q[$];
  rec_t        cur;
  logic        cur_valid = 1'b0;
  logic [14:0] m_pc = '0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rec_t mk(input logic [15:0] ins, input logic [14:0] av);
    rec_t r;
    r = '0;
    r.instr = ins;
    r.aval  = av;
    r.e_pc  = m_pc;
    return r;
  endfunction

  function automatic void push_reset(input int unsigned n);
    rec_t r;
    for (int unsigned i = 0; i < n; i++) begin
      r = '0;
      r.rst = 1'b1;
      r.chk_ctrl = 1'b1;
      q.push_back(r);
    end
    m_pc = '0;
  endfunction

  // Expand one instruction into its expected cycle sequence from the ISA rules
  function automatic void gen(input logic [15:0] ins, input logic [14:0] av,
                              input bit zr, input bit ng,
                              input int unsigned fw, input int unsigned rw, input int unsigned ww,
                              input bit noise, input bit rst_wr);
    rec_t r;
    bit c;
    bit jmp;
    logic [5:0] alu;
    c   = ins[15];
    alu = c ? ins[11:6] : 6'b0;
    for (int unsigned i = 0; i < fw; i++) begin
      r = mk(16'hBEEF, av);
      r.mack = noise;
      r.e_ireq = 1'b1;
      q.push_back(r);
    end
    r = mk(ins, av);
    r.iack = 1'b1;
    r.e_ireq = 1'b1;
    q.push_back(r);
    // decode cycle
    r = mk(16'hBEEF, av);
    r.iack = noise;
    r.mack = noise;
    r.chk_ctrl = 1'b1;
    r.e_alu = alu;
    r.e_am = c & ins[12];
    if (!c) begin
      r.e_la = 1'b1;
      q.push_back(r);
      m_pc = m_pc + 15'd1;
      return;
    end
    q.push_back(r);
    if (ins[12]) begin
      for (int unsigned i = 0; i <= rw; i++) begin
        r = mk(16'hBEEF, av);
        r.chk_ctrl = 1'b1; r.e_alu = alu; r.e_am = ins[12];
        r.e_mreq = 1'b1;
        r.mack = (i == rw);
        r.e_mload = (i == rw);
        q.push_back(r);
      end
    end
    r = mk(16'hBEEF, av);
    r.chk_ctrl = 1'b1; r.e_alu = alu; r.e_am = ins[12];
    r.zr = zr; r.ng = ng;
    r.iack = noise; r.mack = noise;
    q.push_back(r);
    if (ins[3]) begin
      for (int unsigned i = 0; i <= ww; i++) begin
        r = mk(16'hBEEF, av);
        r.chk_ctrl = 1'b1; r.e_alu = alu; r.e_am = ins[12];
        r.e_mreq = 1'b1; r.e_mwe = 1'b1;
        r.mack = (i == ww);
        q.push_back(r);
        if (rst_wr) begin
          push_reset(2);
          return;
        end
      end
    end
    jmp = (ins[2] & ng) | (ins[1] & zr) | (ins[0] & ~ng & ~zr);
    r = mk(16'hBEEF, av);
    r.chk_ctrl = 1'b1; r.e_alu = alu; r.e_am = ins[12];
    r.zr = ~zr; r.ng = ~ng;
    r.iack = noise; r.mack = noise;
    r.e_la = ins[5]; r.e_asel = 1'b1; r.e_ld = ins[4];
    q.push_back(r);
    m_pc = jmp ? av : m_pc + 15'd1;
  endfunction

  task automatic drive(input rec_t r);
    reset         = r.rst;
    bus.instr_ack = r.iack;
    bus.instr     = r.instr;
    bus.a_val     = r.aval;
    bus.mem_ack   = r.mack;
    bus.alu_zr    = r.zr;
    bus.alu_ng    = r.ng;
  endtask

  // Play queued cycles, then check the committed pc against a hand-derived literal
  task automatic run(input string nm, input logic [14:0] lit_pc);
    rec_t idle;
    while (q.size() > 0) begin
      @(negedge clk);
      cur = q.pop_front();
      drive(cur);
      cur_valid = 1'b1;
    end
    @(negedge clk);
    cur_valid = 1'b0;
    idle = '0;
    drive(idle);
    #3;
    chk({nm, "_pc"}, 32'(bus.pc), 32'(lit_pc));
    chk({nm, "_req"}, 32'(bus.instr_req), 32'd1);
  endtask

  // Per-cycle compare of DUT outputs against the expanded model
  always @(negedge clk) begin
    #2;
    if (cur_valid) begin
      chk("instr_req", 32'(bus.instr_req), 32'(cur.e_ireq));
      chk("pc",        32'(bus.pc),        32'(cur.e_pc));
      chk("mem_req",   32'(bus.mem_req),   32'(cur.e_mreq));
      chk("mem_we",    32'(bus.mem_we),    32'(cur.e_mwe));
      chk("m_load",    32'(bus.m_load),    32'(cur.e_mload));
      chk("load_a",    32'(bus.load_a),    32'(cur.e_la));
      chk("load_d",    32'(bus.load_d),    32'(cur.e_ld));
      if (cur.e_la) chk("a_sel", 32'(bus.a_sel), 32'(cur.e_asel));
      if (cur.chk_ctrl) begin
        chk("alu_ctrl", 32'({bus.zx, bus.nx, bus.zy, bus.ny, bus.f, bus.no}), 32'(cur.e_alu));
        chk("alu_am",   32'(bus.alu_am), 32'(cur.e_am));
      end
    end
  end

  initial begin
    bus.instr_ack = 1'b0;
    bus.instr     = '0;
    bus.a_val     = '0;
    bus.mem_ack   = 1'b0;
    bus.alu_zr    = 1'b0;
    bus.alu_ng    = 1'b0;

    push_reset(2);                                               run("reset",   15'h0000);
    gen(16'h0005, 15'h0000, 0, 0, 0, 0, 0, 0, 0);               run("a_instr", 15'h0001);
    gen(16'hEC10, 15'h0005, 0, 0, 1, 0, 0, 1, 0);               run("d_eq_a",  15'h0002);
    gen(16'hF088, 15'h0010, 0, 0, 0, 0, 3, 0, 0);               run("m_d_m",   15'h0003);
    gen(16'hE301, 15'h0123, 0, 0, 0, 0, 0, 1, 0);               run("jgt_tk",  15'h0123);
    gen(16'hE301, 15'h0123, 1, 0, 0, 0, 0, 0, 0);               run("jgt_nt",  15'h0124);
    gen(16'hE304, 15'h0200, 0, 1, 2, 0, 0, 1, 0);               run("jlt_tk",  15'h0200);
    gen(16'hFCAA, 15'h0040, 1, 0, 0, 2, 2, 1, 0);               run("am_jeq",  15'h0040);
    gen(16'hE307, 15'h7FFF, 0, 1, 0, 0, 0, 0, 0);               run("jmp_max", 15'h7FFF);
    gen(16'h0003, 15'h7FFF, 0, 0, 0, 0, 0, 1, 0);               run("wrap",    15'h0000);
    gen(16'h0007, 15'h0000, 0, 0, 0, 0, 0, 0, 0);               run("a2",      15'h0001);
    gen(16'hF088, 15'h0010, 0, 0, 0, 1, 5, 0, 1);               run("rst_wr",  15'h0000);
    gen(16'h0001, 15'h0000, 0, 0, 0, 0, 0, 0, 0);               run("restart", 15'h0001);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
